// File: rtl/axis_axil_master_pkg.sv
// Shared definitions for the byte-stream to AXI4-Lite bridge: FSM states,
// command opcodes and the single-byte error status codes.
package axis_axil_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WR,
        B,
        RD,
        R,
        RESP
    } state_t;

    localparam logic [7:0] OPC_WRITE      = 8'h01;
    localparam logic [7:0] OPC_READ       = 8'h02;
    localparam logic [7:0] STS_BAD_OPCODE = 8'hEE;
    localparam logic [7:0] STS_TIMEOUT    = 8'hFF;

endpackage

// File: rtl/axis_axil_master.sv
// Turns opcode/address/data command frames on an 8-bit AXI-Stream into single
// AXI4-Lite transactions and returns a status byte (plus read data) as a stream.
module axis_axil_master
    import axis_axil_master_pkg::*;
#(
    parameter int AXIL_ADDR_WIDTH = 32,
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                         clk_i,
    input  logic                         arst_i,

    input  logic [7:0]                   s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,

    output logic [7:0]                   m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,

    output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic [2:0]                   m_axil_awprot,
    output logic                         m_axil_awvalid,
    input  logic                         m_axil_awready,
    output logic [AXIL_DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [AXIL_DATA_WIDTH/8-1:0] m_axil_wstrb,
    output logic                         m_axil_wvalid,
    input  logic                         m_axil_wready,
    input  logic [1:0]                   m_axil_bresp,
    input  logic                         m_axil_bvalid,
    output logic                         m_axil_bready,
    output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic [2:0]                   m_axil_arprot,
    output logic                         m_axil_arvalid,
    input  logic                         m_axil_arready,
    input  logic [AXIL_DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]                   m_axil_rresp,
    input  logic                         m_axil_rvalid,
    output logic                         m_axil_rready
);

    localparam int AB      = AXIL_ADDR_WIDTH / 8;
    localparam int DB      = AXIL_DATA_WIDTH / 8;
    localparam int CNT_MAX = (AB > DB) ? AB : DB;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

    state_t                       state;
    logic                         is_write;
    logic [CNT_W-1:0]             byte_cnt;
    logic [CNT_W-1:0]             resp_left;
    logic [TMO_W-1:0]             tmo_cnt;
    logic [AXIL_ADDR_WIDTH-1:0]   addr_sr;
    logic [AXIL_DATA_WIDTH-1:0]   data_sr;

    logic s_accept;
    logic tmo_hit;
    logic aw_done;
    logic w_done;
    logic unused_tlast;

    assign s_accept = s_axis_tvalid && s_axis_tready;
    assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    // A handshake landing on this edge counts as done, even on the expiry cycle.
    assign aw_done  = !m_axil_awvalid || m_axil_awready;
    assign w_done   = !m_axil_wvalid || m_axil_wready;

    assign m_axil_awaddr = addr_sr;
    assign m_axil_araddr = addr_sr;
    assign m_axil_wdata  = data_sr;
    assign m_axil_wstrb  = '1;
    assign m_axil_awprot = 3'b000;
    assign m_axil_arprot = 3'b000;
    assign unused_tlast  = s_axis_tlast;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state          <= IDLE;
            is_write       <= 1'b0;
            byte_cnt       <= '0;
            resp_left      <= '0;
            tmo_cnt        <= '0;
            addr_sr        <= '0;
            data_sr        <= '0;
            s_axis_tready  <= 1'b0;
            m_axis_tdata   <= '0;
            m_axis_tvalid  <= 1'b0;
            m_axis_tlast   <= 1'b0;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
        end else begin
            // Every transition below overrides this with a clear.
            tmo_cnt <= tmo_hit ? tmo_cnt : tmo_cnt + 1'b1;

            unique case (state)
                IDLE: begin
                    s_axis_tready <= 1'b1;
                    if (s_accept) begin
                        tmo_cnt  <= '0;
                        byte_cnt <= '0;
                        if (s_axis_tdata == OPC_WRITE || s_axis_tdata == OPC_READ) begin
                            is_write <= (s_axis_tdata == OPC_WRITE);
                            state    <= ADDR;
                        end else begin
                            s_axis_tready <= 1'b0;
                            m_axis_tdata  <= STS_BAD_OPCODE;
                            m_axis_tvalid <= 1'b1;
                            m_axis_tlast  <= 1'b1;
                            resp_left     <= '0;
                            state         <= RESP;
                        end
                    end
                end

                ADDR: begin
                    if (s_accept) begin
                        addr_sr <= AXIL_ADDR_WIDTH'({addr_sr, s_axis_tdata});
                        if (byte_cnt == CNT_W'(AB - 1)) begin
                            byte_cnt <= '0;
                            tmo_cnt  <= '0;
                            if (is_write) begin
                                state <= WDATA;
                            end else begin
                                s_axis_tready  <= 1'b0;
                                m_axil_arvalid <= 1'b1;
                                state          <= RD;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end

                WDATA: begin
                    if (s_accept) begin
                        data_sr <= AXIL_DATA_WIDTH'({data_sr, s_axis_tdata});
                        if (byte_cnt == CNT_W'(DB - 1)) begin
                            byte_cnt       <= '0;
                            tmo_cnt        <= '0;
                            s_axis_tready  <= 1'b0;
                            m_axil_awvalid <= 1'b1;
                            m_axil_wvalid  <= 1'b1;
                            state          <= WR;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end

                WR: begin
                    if (m_axil_awvalid && m_axil_awready) m_axil_awvalid <= 1'b0;
                    if (m_axil_wvalid && m_axil_wready)   m_axil_wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        tmo_cnt       <= '0;
                        m_axil_bready <= 1'b1;
                        state         <= B;
                    end else if (tmo_hit) begin
                        tmo_cnt        <= '0;
                        m_axil_awvalid <= 1'b0;
                        m_axil_wvalid  <= 1'b0;
                        m_axis_tdata   <= STS_TIMEOUT;
                        m_axis_tvalid  <= 1'b1;
                        m_axis_tlast   <= 1'b1;
                        resp_left      <= '0;
                        state          <= RESP;
                    end
                end

                B: begin
                    if (m_axil_bvalid) begin
                        tmo_cnt       <= '0;
                        m_axil_bready <= 1'b0;
                        m_axis_tdata  <= {6'b0, m_axil_bresp};
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b1;
                        resp_left     <= '0;
                        state         <= RESP;
                    end else if (tmo_hit) begin
                        tmo_cnt       <= '0;
                        m_axil_bready <= 1'b0;
                        m_axis_tdata  <= STS_TIMEOUT;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b1;
                        resp_left     <= '0;
                        state         <= RESP;
                    end
                end

                RD: begin
                    if (m_axil_arready) begin
                        tmo_cnt        <= '0;
                        m_axil_arvalid <= 1'b0;
                        m_axil_rready  <= 1'b1;
                        state          <= R;
                    end else if (tmo_hit) begin
                        tmo_cnt        <= '0;
                        m_axil_arvalid <= 1'b0;
                        m_axis_tdata   <= STS_TIMEOUT;
                        m_axis_tvalid  <= 1'b1;
                        m_axis_tlast   <= 1'b1;
                        resp_left      <= '0;
                        state          <= RESP;
                    end
                end

                R: begin
                    if (m_axil_rvalid) begin
                        tmo_cnt       <= '0;
                        m_axil_rready <= 1'b0;
                        data_sr       <= m_axil_rdata;
                        m_axis_tdata  <= {6'b0, m_axil_rresp};
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b0;
                        resp_left     <= CNT_W'(DB);
                        state         <= RESP;
                    end else if (tmo_hit) begin
                        tmo_cnt       <= '0;
                        m_axil_rready <= 1'b0;
                        m_axis_tdata  <= STS_TIMEOUT;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b1;
                        resp_left     <= '0;
                        state         <= RESP;
                    end
                end

                RESP: begin
                    if (m_axis_tvalid && m_axis_tready) begin
                        if (resp_left == '0) begin
                            tmo_cnt       <= '0;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            s_axis_tready <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            m_axis_tdata <= data_sr[AXIL_DATA_WIDTH-1 -: 8];
                            data_sr      <= data_sr << 8;
                            resp_left    <= resp_left - 1'b1;
                            m_axis_tlast <= (resp_left == CNT_W'(1));
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_axil_master.sv
// Scoreboard bench for axis_axil_master: directed command frames, an AXI4-Lite
// slave model with configurable ready behaviour, and a response-stream monitor.
`timescale 1ns/1ps
module tb_axis_axil_master;

    logic        clk_i = 1'b0;
    logic        arst_i;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    always #5 clk_i = ~clk_i;

    axis_axil_master #(
        .AXIL_ADDR_WIDTH(32),
        .AXIL_DATA_WIDTH(32),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clk_i         (clk_i),
        .arst_i        (arst_i),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axil_awaddr (awaddr),
        .m_axil_awprot (awprot),
        .m_axil_awvalid(awvalid),
        .m_axil_awready(awready),
        .m_axil_wdata  (wdata),
        .m_axil_wstrb  (wstrb),
        .m_axil_wvalid (wvalid),
        .m_axil_wready (wready),
        .m_axil_bresp  (bresp),
        .m_axil_bvalid (bvalid),
        .m_axil_bready (bready),
        .m_axil_araddr (araddr),
        .m_axil_arprot (arprot),
        .m_axil_arvalid(arvalid),
        .m_axil_arready(arready),
        .m_axil_rdata  (rdata),
        .m_axil_rresp  (rresp),
        .m_axil_rvalid (rvalid),
        .m_axil_rready (rready)
    );

    int checks   = 0;
    int failures = 0;
    logic [8:0] exp_q[$];

    logic [31:0] exp_addr  = 32'h0;
    logic [31:0] exp_wdata = 32'h0;
    logic [31:0] cfg_rdata = 32'h0;
    logic [1:0]  cfg_bresp = 2'b00;
    logic [1:0]  cfg_rresp = 2'b00;
    int aw_delay    = 0;
    bit w_first     = 1'b0;
    bit ar_block    = 1'b0;
    bit rand_tready = 1'b0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int aw_hi_cnt = 0, aw_wait = 0;
    bit aw_got = 1'b0, w_got = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // AXI4-Lite slave model: handshakes sampled on the falling edge, inputs
    // updated just after the rising edge.
    initial begin
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        forever begin
            @(negedge clk_i);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            b_hs  = bvalid && bready;
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            if (awvalid) aw_hi_cnt++;
            if (aw_hs) begin
                aw_cnt++;
                check("awaddr", 64'(awaddr), 64'(exp_addr));
                check("awprot", 64'(awprot), 64'h0);
            end
            if (w_hs) begin
                w_cnt++;
                check("wdata", 64'(wdata), 64'(exp_wdata));
                check("wstrb", 64'(wstrb), 64'hF);
            end
            if (b_hs) b_cnt++;
            if (ar_hs) begin
                ar_cnt++;
                check("araddr", 64'(araddr), 64'(exp_addr));
                check("arprot", 64'(arprot), 64'h0);
            end
            if (r_hs) r_cnt++;
            if (awvalid && !awready) aw_wait++;
            else if (!awvalid) aw_wait = 0;

            @(posedge clk_i);
            #2;
            if (arst_i) begin
                bvalid = 1'b0; rvalid = 1'b0;
                aw_got = 1'b0; w_got = 1'b0; aw_wait = 0;
            end else begin
                if (aw_hs) aw_got = 1'b1;
                if (w_hs)  w_got  = 1'b1;
                if (b_hs)  bvalid = 1'b0;
                if (aw_got && w_got && !bvalid) begin
                    bvalid = 1'b1; bresp = cfg_bresp;
                    aw_got = 1'b0; w_got = 1'b0;
                end
                if (r_hs) rvalid = 1'b0;
                if (ar_hs) begin
                    rvalid = 1'b1; rdata = cfg_rdata; rresp = cfg_rresp;
                end
            end
            if (w_first) begin
                wready  = !w_got;
                awready = w_got && !aw_got;
            end else begin
                wready  = 1'b1;
                awready = (aw_wait >= aw_delay);
            end
            arready = !ar_block;
        end
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk_i);
            #2;
            m_tready = rand_tready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Response monitor: pops the scoreboard on every m_axis handshake.
    initial begin
        logic [7:0] held;
        logic [8:0] e;
        bit pend;
        pend = 1'b0;
        held = 8'h0;
        forever begin
            @(negedge clk_i);
            if (arst_i) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    check("tvalid_hold", 64'(m_tvalid), 64'h1);
                    check("tdata_stable", 64'(m_tdata), 64'(held));
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL resp_unexpected actual=%0h required=none", {m_tlast, m_tdata});
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_byte", 64'({m_tlast, m_tdata}), 64'(e));
                    end
                end
                pend = m_tvalid && !m_tready;
                held = m_tdata;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk_i);
        s_tdata  = b;
        s_tvalid = 1'b1;
        while (!s_tready && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        if (!s_tready) begin
            checks++;
            failures++;
            $display("FAIL s_tready_wait actual=0 required=1");
        end
        @(posedge clk_i);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_write(input logic [31:0] a, input logic [31:0] d);
        exp_addr  = a;
        exp_wdata = d;
        send_byte(8'h01);
        for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
    endtask

    task automatic send_read(input logic [31:0] a);
        exp_addr = a;
        send_byte(8'h02);
        for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
    endtask

    task automatic expect_read(input logic [1:0] rr, input logic [31:0] d);
        exp_q.push_back({1'b0, 6'b0, rr});
        exp_q.push_back({1'b0, d[31:24]});
        exp_q.push_back({1'b0, d[23:16]});
        exp_q.push_back({1'b0, d[15:8]});
        exp_q.push_back({1'b1, d[7:0]});
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain actual=%0d bytes pending required=0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk_i);
    endtask

    initial begin
        int n;
        arst_i = 1'b1;
        s_tdata = 8'h0; s_tvalid = 1'b0; s_tlast = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_s_tready", 64'(s_tready), 64'h0);
        check("rst_m_tvalid", 64'(m_tvalid), 64'h0);
        check("rst_m_tlast", 64'(m_tlast), 64'h0);
        check("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'h0);
        check("rst_awaddr", 64'(awaddr), 64'h0);
        check("rst_wdata", 64'(wdata), 64'h0);
        arst_i = 1'b0;
        #1;
        check("s_tready_before_edge", 64'(s_tready), 64'h0);
        @(posedge clk_i);
        #1;
        check("s_tready_first_edge", 64'(s_tready), 64'h1);

        // Write, OKAY
        cfg_bresp = 2'b00;
        exp_q.push_back(9'h100);
        send_write(32'h0000_0010, 32'hDEAD_BEEF);
        drain("write");
        check("write_aw_cnt", 64'(aw_cnt), 64'd1);
        check("write_w_cnt", 64'(w_cnt), 64'd1);
        check("write_b_cnt", 64'(b_cnt), 64'd1);

        // Read, SLVERR
        cfg_rdata = 32'h1234_5678;
        cfg_rresp = 2'b10;
        expect_read(2'b10, 32'h1234_5678);
        send_read(32'h0000_0020);
        drain("read");
        check("read_ar_cnt", 64'(ar_cnt), 64'd1);
        check("read_r_cnt", 64'(r_cnt), 64'd1);

        // Bad opcode, then a normal read
        exp_q.push_back(9'h1EE);
        send_byte(8'h07);
        drain("bad_opcode");
        cfg_rdata = 32'hCAFE_F00D;
        cfg_rresp = 2'b00;
        expect_read(2'b00, 32'hCAFE_F00D);
        send_read(32'h0000_0044);
        drain("after_bad");
        check("after_bad_ar_cnt", 64'(ar_cnt), 64'd2);

        // AW never ready: W completes, timeout still reported
        aw_delay  = 100000;
        aw_hi_cnt = 0;
        exp_q.push_back(9'h1FF);
        send_write(32'h0000_0050, 32'h1122_3344);
        drain("timeout");
        check("timeout_aw_cycles", 64'(aw_hi_cnt), 64'd1024);
        check("timeout_awvalid_low", 64'(awvalid), 64'h0);
        check("timeout_aw_cnt", 64'(aw_cnt), 64'd1);
        check("timeout_w_cnt", 64'(w_cnt), 64'd2);
        check("timeout_b_cnt", 64'(b_cnt), 64'd1);
        w_got    = 1'b0;
        aw_delay = 0;
        exp_q.push_back(9'h100);
        send_write(32'h0000_0054, 32'h5566_7788);
        drain("after_timeout");
        check("after_timeout_aw_cnt", 64'(aw_cnt), 64'd2);
        check("after_timeout_b_cnt", 64'(b_cnt), 64'd2);

        // AW handshake on the expiry cycle wins over the timeout
        aw_delay  = 1023;
        aw_hi_cnt = 0;
        cfg_bresp = 2'b01;
        exp_q.push_back(9'h101);
        send_write(32'h0000_0058, 32'h99AA_BBCC);
        drain("expiry_handshake");
        check("expiry_aw_cycles", 64'(aw_hi_cnt), 64'd1024);
        check("expiry_aw_cnt", 64'(aw_cnt), 64'd3);
        aw_delay  = 0;
        cfg_bresp = 2'b00;

        // Backpressure and W-before-AW ordering
        rand_tready = 1'b1;
        w_first     = 1'b1;
        exp_q.push_back(9'h100);
        send_write(32'h0000_0060, 32'hA5A5_5A5A);
        drain("bp_write");
        cfg_rdata = 32'h8765_4321;
        cfg_rresp = 2'b01;
        expect_read(2'b01, 32'h8765_4321);
        send_read(32'h0000_0064);
        drain("bp_read");
        check("bp_aw_cnt", 64'(aw_cnt), 64'd4);
        check("bp_w_cnt", 64'(w_cnt), 64'd5);
        check("bp_b_cnt", 64'(b_cnt), 64'd4);
        check("bp_ar_cnt", 64'(ar_cnt), 64'd3);
        rand_tready = 1'b0;
        w_first     = 1'b0;

        // Reset while arvalid is pending
        ar_block = 1'b1;
        send_read(32'h0000_0030);
        n = 0;
        while (!arvalid && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("arvalid_before_reset", 64'(arvalid), 64'h1);
        @(negedge clk_i);
        arst_i = 1'b1;
        #1;
        check("reset_arvalid", 64'(arvalid), 64'h0);
        check("reset_s_tready", 64'(s_tready), 64'h0);
        check("reset_m_tvalid", 64'(m_tvalid), 64'h0);
        check("reset_araddr", 64'(araddr), 64'h0);
        repeat (2) @(negedge clk_i);
        ar_block = 1'b0;
        arst_i   = 1'b0;
        cfg_rdata = 32'h0BAD_F00D;
        cfg_rresp = 2'b00;
        expect_read(2'b00, 32'h0BAD_F00D);
        send_read(32'h0000_0034);
        drain("after_reset");
        repeat (20) @(negedge clk_i);
        check("reset_ar_cnt", 64'(ar_cnt), 64'd4);
        check("reset_r_cnt", 64'(r_cnt), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
